mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles to wait for ext_ack before the access is aborted.
REQ-002 Parameter LEDW, default 16: width of the LED output register.
REQ-003 clock  input  1  the only clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  global run request from the board.
REQ-006 enable  output  1  processor enable; it is low while the block stalls the processor.
REQ-007 mem_wr, mem_rd  input  1 each  processor store and load strobes; mem_rd is decoded from opcode 6'h23 at top level.
REQ-008 mem_addr, mem_writedata  input  32 each  processor data address and store data.
REQ-009 mem_readdata  output  32  load data returned to the processor.
REQ-010 dmem_addr, dmem_wdata  output  32 each; dmem_wr  output  1; dmem_rdata  input  32. This is the data-memory port, with combinational read.
REQ-011 ext_req  output  1; ext_we  output  1; ext_addr, ext_wdata  output  32 each; ext_ack  input  1; ext_rdata  input  32. This is the slow-slave handshake port.
REQ-012 keyb  input  32  keyboard scancode; led  output  LEDW; period  output  32  sound period; bus_err  output  1  sticky timeout flag.

Function
REQ-013 Decode on mem_addr[31:16]: 16'h1001 selects DMEM, 16'h1002 selects EXT, 16'h1003 selects IO; any other address reads 0 and ignores writes.
REQ-014 DMEM path:
- dmem_addr equals mem_addr.
- dmem_wdata equals mem_writedata.
- dmem_wr equals mem_wr & enable & DMEM select.
- A load returns dmem_rdata in the same cycle.
REQ-015 IO map, decoded on mem_addr[3:2]:
- 0: cycle counter, read-only.
- 1: led, read/write; writes take the low LEDW bits.
- 2: period, read/write.
- 3: keyb, read-only.
REQ-016 The cycle counter is 32 bits, increments every cycle, and wraps from 32'hFFFF_FFFF to 0.
REQ-017 IO register writes occur only on a clock edge with enable high.
REQ-018 The FSM has three states: IDLE, WAIT, DONE.
REQ-019 enable = run & ~stall. stall is high in IDLE when (mem_rd|mem_wr) & EXT select, and high in all of WAIT; stall is low in DONE.
REQ-020 IDLE->WAIT when run & (mem_rd|mem_wr) & EXT select. On that edge the block latches ext_addr, ext_wdata and ext_we (= mem_wr).
REQ-021 In WAIT, ext_req is high and ext_addr, ext_wdata and ext_we are stable.
REQ-022 WAIT->DONE on ext_ack. On that edge ext_rdata is captured into rdata_q and the wait counter clears.
REQ-023 In WAIT the wait counter increments each cycle. When it reaches TIMEOUT-1 without ext_ack, the FSM goes WAIT->DONE, rdata_q becomes 32'hDEAD_BEEF, and bus_err is set.
REQ-024 If ext_ack and the timeout occur on the same edge, ext_ack wins: data is captured and bus_err is not set.
REQ-025 In DONE, mem_readdata = rdata_q and ext_req is low; DONE->IDLE after one cycle.
REQ-026 The DONE state completes exactly one instruction, giving a minimum EXT access latency of 3 cycles when ack arrives in the first WAIT cycle.
REQ-027 ext_ack is ignored in IDLE and DONE.
REQ-028 When run is low, enable is low and the FSM does not leave IDLE. An access already in WAIT or DONE runs to completion.
REQ-029 bus_err stays set until reset.

Reset
REQ-030 Reset values while reset is low:
- State: FSM = IDLE; counter, wait counter, rdata_q, led and period = 0; bus_err = 0.
- Outputs: ext_req = 0 and enable = 0.
REQ-031 Assertion mid-access aborts any WAIT immediately and ext_req drops asynchronously. After release, the FSM starts from IDLE.

Structure
REQ-032 A shared package holds:
- the region constants 16'h1001, 16'h1002 and 16'h1003;
- the IO offset constants;
- the error word 32'hDEAD_BEEF;
- the FSM state enum.
REQ-033 IO registers are placed in one sub-module, io_regs, which contains the counter, led, period and the read mux.

Verification
REQ-034 Reset held low for 3 cycles, then released -> enable = run, led = 0, period = 0, bus_err = 0, ext_req = 0.
REQ-035 Store 32'h0000_00A5 to 32'h1003_0004, then load from the same address -> led = 16'h00A5 on the next edge; the load returns 32'h0000_00A5.
REQ-036 Load from 32'h1002_0010 with ext_ack arriving 2 cycles after ext_req rises and ext_rdata = 32'h1234_5678 -> enable is low for 3 cycles; mem_readdata = 32'h1234_5678 in DONE.
REQ-037 Load from EXT with ext_ack never asserted, TIMEOUT = 8 -> WAIT lasts 8 cycles; mem_readdata = 32'hDEAD_BEEF; bus_err = 1 and remains 1.
REQ-038 Store to EXT with reset asserted during WAIT -> ext_req drops asynchronously, FSM = IDLE, no stale DONE after release.
REQ-039 Counter preloaded to 32'hFFFF_FFFF via force -> it reads 0 on the next cycle; a store to 32'h1001_0000 with run low -> dmem_wr stays 0.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared constants for the memory bus controller: address regions, IO offsets,
// the timeout error word and the access FSM state encoding.
package mem_bus_ctrl_pkg;

    localparam logic [15:0] REGION_DMEM = 16'h1001;
    localparam logic [15:0] REGION_EXT  = 16'h1002;
    localparam logic [15:0] REGION_IO   = 16'h1003;

    localparam logic [1:0] IO_CNT    = 2'd0;
    localparam logic [1:0] IO_LED    = 2'd1;
    localparam logic [1:0] IO_PERIOD = 2'd2;
    localparam logic [1:0] IO_KEYB   = 2'd3;

    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Handshake port towards the slow external slave; the controller is the master.
interface mem_bus_ctrl_if;

    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_ack;
    logic [31:0] ext_rdata;

    modport master (
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_ack, ext_rdata
    );

    modport slave (
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_ack, ext_rdata
    );

endinterface

// File: rtl/mem_bus_ctrl_io_regs.sv
// Memory-mapped IO block: free-running cycle counter, LED and sound-period
// registers, keyboard input, and the read mux selected by word offset.
module io_regs
    import mem_bus_ctrl_pkg::*;
#(
    parameter int LEDW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            we,
    input  logic [1:0]      offset,
    input  logic [31:0]     wdata,
    input  logic [31:0]     keyb,
    output logic [31:0]     rdata,
    output logic [LEDW-1:0] led,
    output logic [31:0]     period
);

    logic [31:0] cnt;

    // The counter runs regardless of the processor; only explicit stores touch led/period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            led    <= '0;
            period <= '0;
        end else begin
            cnt <= cnt + 32'd1;
            if (we) begin
                case (offset)
                    IO_LED:    led    <= wdata[LEDW-1:0];
                    IO_PERIOD: period <= wdata;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            IO_CNT:    rdata = cnt;
            IO_LED:    rdata = 32'(led);
            IO_PERIOD: rdata = period;
            IO_KEYB:   rdata = keyb;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-bus decoder for the processor: routes accesses to DMEM, IO registers or a
// slow external slave, stalling the processor while the external handshake runs.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int LEDW    = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    output logic            enable,
    input  logic            mem_wr,
    input  logic            mem_rd,
    input  logic [31:0]     mem_addr,
    input  logic [31:0]     mem_writedata,
    output logic [31:0]     mem_readdata,
    output logic [31:0]     dmem_addr,
    output logic [31:0]     dmem_wdata,
    output logic            dmem_wr,
    input  logic [31:0]     dmem_rdata,
    mem_bus_ctrl_if.master  ext,
    input  logic [31:0]     keyb,
    output logic [LEDW-1:0] led,
    output logic [31:0]     period,
    output logic            bus_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t      state;
    logic [CW-1:0] wait_cnt;
    logic [31:0] rdata_q;
    logic [31:0] ext_addr_q;
    logic [31:0] ext_wdata_q;
    logic        ext_we_q;
    logic [31:0] io_rdata;
    logic        sel_dmem;
    logic        sel_ext;
    logic        sel_io;
    logic        access;
    logic        stall;

    assign sel_dmem = (mem_addr[31:16] == REGION_DMEM);
    assign sel_ext  = (mem_addr[31:16] == REGION_EXT);
    assign sel_io   = (mem_addr[31:16] == REGION_IO);
    assign access   = mem_rd | mem_wr;

    // Reset is folded in so the processor is held off while the block is in reset.
    assign stall  = ((state == ST_IDLE) & access & sel_ext) | (state == ST_WAIT);
    assign enable = reset & run & ~stall;

    assign dmem_addr  = mem_addr;
    assign dmem_wdata = mem_writedata;
    assign dmem_wr    = mem_wr & enable & sel_dmem;

    assign ext.ext_req   = (state == ST_WAIT);
    assign ext.ext_addr  = ext_addr_q;
    assign ext.ext_wdata = ext_wdata_q;
    assign ext.ext_we    = ext_we_q;

    // ext_ack beats the timeout on the same edge, so real data is never replaced by ERR_WORD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            rdata_q     <= '0;
            bus_err     <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_we_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run && access && sel_ext) begin
                        state       <= ST_WAIT;
                        ext_addr_q  <= mem_addr;
                        ext_wdata_q <= mem_writedata;
                        ext_we_q    <= mem_wr;
                    end
                end
                ST_WAIT: begin
                    if (ext.ext_ack) begin
                        state    <= ST_DONE;
                        rdata_q  <= ext.ext_rdata;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state    <= ST_DONE;
                        rdata_q  <= ERR_WORD;
                        bus_err  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_readdata = '0;
        if (state == ST_DONE) begin
            mem_readdata = rdata_q;
        end else if (sel_dmem) begin
            mem_readdata = dmem_rdata;
        end else if (sel_io) begin
            mem_readdata = io_rdata;
        end
    end

    io_regs #(
        .LEDW(LEDW)
    ) u_io (
        .clock (clock),
        .reset (reset),
        .we    (mem_wr & enable & sel_io),
        .offset(mem_addr[3:2]),
        .wdata (mem_writedata),
        .keyb  (keyb),
        .rdata (io_rdata),
        .led   (led),
        .period(period)
    );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl; load data is scoreboarded at
// issue time and compared when the controller hands it back to the processor.
module tb_mem_bus_ctrl;

    localparam int TIMEOUT = 8;
    localparam int LEDW    = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            run = 1'b1;
    logic            mem_wr = 1'b0;
    logic            mem_rd = 1'b0;
    logic [31:0]     mem_addr = '0;
    logic [31:0]     mem_writedata = '0;
    logic [31:0]     dmem_rdata = '0;
    logic [31:0]     keyb = '0;
    logic            enable;
    logic            dmem_wr;
    logic            bus_err;
    logic [31:0]     mem_readdata;
    logic [31:0]     dmem_addr;
    logic [31:0]     dmem_wdata;
    logic [31:0]     period;
    logic [LEDW-1:0] led;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rd_q[$];

    mem_bus_ctrl_if bus();

    always #5 clock = ~clock;

    mem_bus_ctrl #(
        .TIMEOUT(TIMEOUT),
        .LEDW(LEDW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .run(run),
        .enable(enable),
        .mem_wr(mem_wr),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_wr(dmem_wr),
        .dmem_rdata(dmem_rdata),
        .ext(bus),
        .keyb(keyb),
        .led(led),
        .period(period),
        .bus_err(bus_err)
    );

    task automatic apply_stimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                  input logic [31:0] wdata);
        mem_wr        = wr;
        mem_rd        = rd;
        mem_addr      = addr;
        mem_writedata = wdata;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Pops the oldest outstanding load result and compares it with mem_readdata.
    task automatic check_read(input string tag);
        logic [31:0] expected;
        if (rd_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected <none queued>", tag, mem_readdata);
        end else begin
            expected = rd_q.pop_front();
            check_output(tag, mem_readdata, expected);
        end
    endtask

    // Runs one external access; ack_cycle counts WAIT cycles from 1, 0 means never ack.
    task automatic ext_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_cycle, input logic [31:0] ack_data,
                              output int low_cycles, output int wait_cycles);
        int budget;
        budget      = 0;
        low_cycles  = 0;
        wait_cycles = 0;
        apply_stimulus(wr, !wr, addr, wdata);
        #1;
        check_output("ext_req_idle", 32'(bus.ext_req), 32'd0);
        while (!enable && budget < 40) begin
            low_cycles++;
            @(negedge clock);
            bus.ext_ack = 1'b0;
            if (bus.ext_req) begin
                wait_cycles++;
                check_output("ext_addr", bus.ext_addr, addr);
                check_output("ext_wdata", bus.ext_wdata, wdata);
                check_output("ext_we", 32'(bus.ext_we), 32'(wr));
                if (wait_cycles == ack_cycle) begin
                    bus.ext_ack   = 1'b1;
                    bus.ext_rdata = ack_data;
                end
            end
            #1;
            budget++;
        end
        check_output("enable_done", 32'(enable), 32'd1);
        check_output("ext_req_done", 32'(bus.ext_req), 32'd0);
        if (!wr) check_read("ext_load_data");
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int low;
        int waits;
        bus.ext_ack   = 1'b0;
        bus.ext_rdata = '0;

        repeat (3) @(negedge clock);
        #1;
        check_output("enable_in_reset", 32'(enable), 32'd0);
        check_output("ext_req_in_reset", 32'(bus.ext_req), 32'd0);

        @(negedge clock);
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b1, 32'h1003_0000, 32'h0);
        rd_q.push_back(32'd0);
        #1;
        check_output("enable_after_reset", 32'(enable), 32'(run));
        check_output("led_reset", 32'(led), 32'd0);
        check_output("period_reset", period, 32'd0);
        check_output("bus_err_reset", 32'(bus_err), 32'd0);
        check_output("ext_req_reset", 32'(bus.ext_req), 32'd0);
        check_read("counter_zero");

        @(negedge clock);
        rd_q.push_back(32'd1);
        #1;
        check_read("counter_one");

        @(negedge clock);
        apply_stimulus(1'b1, 1'b0, 32'h1003_0004, 32'h0000_00A5);
        #1;
        check_output("enable_io_store", 32'(enable), 32'd1);
        @(negedge clock);
        apply_stimulus(1'b0, 1'b1, 32'h1003_0004, 32'h0);
        rd_q.push_back(32'h0000_00A5);
        #1;
        check_output("led_written", 32'(led), 32'h0000_00A5);
        check_read("led_load");

        @(negedge clock);
        apply_stimulus(1'b1, 1'b0, 32'h1003_0008, 32'h0001_2345);
        @(negedge clock);
        apply_stimulus(1'b0, 1'b1, 32'h1003_0008, 32'h0);
        rd_q.push_back(32'h0001_2345);
        #1;
        check_output("period_written", period, 32'h0001_2345);
        check_read("period_load");

        @(negedge clock);
        keyb = 32'hCAFE_F00D;
        apply_stimulus(1'b0, 1'b1, 32'h1003_000C, 32'h0);
        rd_q.push_back(32'hCAFE_F00D);
        #1;
        check_read("keyb_load");

        @(negedge clock);
        apply_stimulus(1'b1, 1'b0, 32'h1001_0040, 32'h7777_0000);
        #1;
        check_output("dmem_wr_store", 32'(dmem_wr), 32'd1);
        check_output("dmem_addr", dmem_addr, 32'h1001_0040);
        check_output("dmem_wdata", dmem_wdata, 32'h7777_0000);
        @(negedge clock);
        dmem_rdata = 32'h55AA_1234;
        apply_stimulus(1'b0, 1'b1, 32'h1001_0040, 32'h0);
        rd_q.push_back(32'h55AA_1234);
        #1;
        check_output("dmem_wr_load", 32'(dmem_wr), 32'd0);
        check_read("dmem_load");

        @(negedge clock);
        apply_stimulus(1'b1, 1'b0, 32'h2000_0004, 32'h0000_FFFF);
        #1;
        check_output("dmem_wr_unmapped", 32'(dmem_wr), 32'd0);
        @(negedge clock);
        apply_stimulus(1'b0, 1'b1, 32'h2000_0004, 32'h0);
        rd_q.push_back(32'd0);
        #1;
        check_output("led_unmapped_store", 32'(led), 32'h0000_00A5);
        check_read("unmapped_load");

        @(negedge clock);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
        bus.ext_ack = 1'b1;
        @(negedge clock);
        bus.ext_ack = 1'b0;
        #1;
        check_output("ack_idle_req", 32'(bus.ext_req), 32'd0);
        check_output("ack_idle_enable", 32'(enable), 32'd1);

        @(negedge clock);
        rd_q.push_back(32'h1234_5678);
        ext_access(1'b0, 32'h1002_0010, 32'h0, 2, 32'h1234_5678, low, waits);
        check_output("ext_low_cycles", 32'(low), 32'd3);
        check_output("ext_wait_cycles", 32'(waits), 32'd2);

        @(negedge clock);
        rd_q.push_back(32'h0BAD_F00D);
        ext_access(1'b0, 32'h1002_0014, 32'h0, 1, 32'h0BAD_F00D, low, waits);
        check_output("ext_min_low", 32'(low), 32'd2);

        @(negedge clock);
        rd_q.push_back(32'h600D_D00D);
        ext_access(1'b0, 32'h1002_0018, 32'h0, TIMEOUT, 32'h600D_D00D, low, waits);
        check_output("ack_vs_timeout_low", 32'(low), 32'(TIMEOUT + 1));
        check_output("ack_vs_timeout_err", 32'(bus_err), 32'd0);

        @(negedge clock);
        ext_access(1'b1, 32'h1002_0024, 32'hA5A5_5A5A, 1, 32'h0, low, waits);
        check_output("ext_store_low", 32'(low), 32'd2);

        @(negedge clock);
        rd_q.push_back(32'hDEAD_BEEF);
        ext_access(1'b0, 32'h1002_0030, 32'h0, 0, 32'h0, low, waits);
        check_output("timeout_wait_cycles", 32'(waits), 32'(TIMEOUT));
        check_output("timeout_bus_err", 32'(bus_err), 32'd1);

        @(negedge clock);
        rd_q.push_back(32'h0000_0042);
        ext_access(1'b0, 32'h1002_0034, 32'h0, 1, 32'h0000_0042, low, waits);
        check_output("bus_err_sticky", 32'(bus_err), 32'd1);

        @(negedge clock);
        apply_stimulus(1'b1, 1'b0, 32'h1002_0040, 32'h1111_2222);
        @(negedge clock);
        #1;
        check_output("abort_req_before", 32'(bus.ext_req), 32'd1);
        check_output("abort_we", 32'(bus.ext_we), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_output("abort_req_async", 32'(bus.ext_req), 32'd0);
        check_output("abort_enable", 32'(enable), 32'd0);
        check_output("abort_bus_err", 32'(bus_err), 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_output("release_req", 32'(bus.ext_req), 32'd0);
        check_output("release_enable", 32'(enable), 32'd1);
        @(negedge clock);
        apply_stimulus(1'b1, 1'b0, 32'h1003_0004, 32'h0000_003C);
        #1;
        check_output("no_stale_req", 32'(bus.ext_req), 32'd0);
        @(negedge clock);
        apply_stimulus(1'b0, 1'b1, 32'h1003_0004, 32'h0);
        rd_q.push_back(32'h0000_003C);
        #1;
        check_read("no_stale_done");

        @(negedge clock);
        force dut.u_io.cnt = 32'hFFFF_FFFF;
        apply_stimulus(1'b0, 1'b1, 32'h1003_0000, 32'h0);
        #1;
        release dut.u_io.cnt;
        rd_q.push_back(32'hFFFF_FFFF);
        check_read("counter_preload");
        @(negedge clock);
        rd_q.push_back(32'd0);
        #1;
        check_read("counter_wrap");

        @(negedge clock);
        run = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h1001_0000, 32'h0000_0001);
        #1;
        check_output("run_low_dmem_wr", 32'(dmem_wr), 32'd0);
        check_output("run_low_enable", 32'(enable), 32'd0);
        @(negedge clock);
        apply_stimulus(1'b1, 1'b0, 32'h1003_0004, 32'h0000_0099);
        @(negedge clock);
        apply_stimulus(1'b0, 1'b1, 32'h1002_0000, 32'h0);
        #1;
        check_output("run_low_led", 32'(led), 32'h0000_003C);
        @(negedge clock);
        #1;
        check_output("run_low_no_wait", 32'(bus.ext_req), 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
        run = 1'b1;

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
